// File: rtl/player_mover.sv
// Player sprite mover: IDLE/CALC/READ/CHECK/LOAD walk with bounds and wall-map checks.
// Optional macro MOVER_WRAP_EN: horizontal out-of-range candidates wrap to the opposite edge.
module player_mover #(
    parameter int STEP    = 4,
    parameter int START_X = 2,
    parameter int START_Y = 2,
    parameter int X_MAX   = 156,
    parameter int Y_MAX   = 116
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        iUp,
    input  logic        iDown,
    input  logic        iLeft,
    input  logic        iRight,
    input  logic        freeze,
    input  logic        busy,
    output logic [10:0] wallAddr,
    input  logic        wallQ,
    output logic [7:0]  nextX,
    output logic [6:0]  nextY,
    output logic [2:0]  dir,
    output logic        ldXY,
    output logic        moving
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        LOAD  = 3'd4
    } state_t;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [8:0] X_MAX9 = 9'(X_MAX);
    localparam logic [8:0] Y_MAX9 = 9'(Y_MAX);

    state_t      state;
    state_t      state_nxt;
    logic        load_go;
    logic        any_req;
    logic        init_pend;
    logic [8:0]  x_minus;
    logic [8:0]  x_plus;
    logic [8:0]  y_minus;
    logic [8:0]  y_plus;
    logic [8:0]  cand_x;
    logic [8:0]  cand_y;
    logic        cand_ok;
    logic [10:0] cand_addr;
    logic [7:0]  held_x;
    logic [6:0]  held_y;

    function automatic logic [2:0] pick_dir(input logic up, input logic down,
                                            input logic left, input logic right);
        if (up) begin
            return DIR_UP;
        end else if (down) begin
            return DIR_DOWN;
        end else if (left) begin
            return DIR_LEFT;
        end else if (right) begin
            return DIR_RIGHT;
        end else begin
            return DIR_NONE;
        end
    endfunction

    assign any_req = iUp | iDown | iLeft | iRight;

    // Negative 9-bit differences land far above any legal maximum, so one compare covers both bounds.
    assign x_minus = {1'b0, nextX} - STEP9;
    assign x_plus  = {1'b0, nextX} + STEP9;
    assign y_minus = {2'b00, nextY} - STEP9;
    assign y_plus  = {2'b00, nextY} + STEP9;

    // Candidate origin for the latched heading and its legality.
    always_comb begin
        cand_x  = {1'b0, nextX};
        cand_y  = {2'b00, nextY};
        cand_ok = 1'b1;
        case (dir)
            DIR_UP: begin
                cand_y  = y_minus;
                cand_ok = (y_minus <= Y_MAX9);
            end
            DIR_DOWN: begin
                cand_y  = y_plus;
                cand_ok = (y_plus <= Y_MAX9);
            end
`ifdef MOVER_WRAP_EN
            DIR_LEFT: begin
                cand_x = (x_minus > X_MAX9) ? X_MAX9 : x_minus;
            end
            DIR_RIGHT: begin
                cand_x = (x_plus > X_MAX9) ? 9'd0 : x_plus;
            end
`else
            DIR_LEFT: begin
                cand_x  = x_minus;
                cand_ok = (x_minus <= X_MAX9);
            end
            DIR_RIGHT: begin
                cand_x  = x_plus;
                cand_ok = (x_plus <= X_MAX9);
            end
`endif
            default: begin
                cand_ok = 1'b0;
            end
        endcase
    end

    // Wall map is 40 cells of 4x4 pixels per row.
    assign cand_addr = 11'(cand_y[8:2]) * 11'd40 + 11'(cand_x[8:2]);

    // Next-state logic; freeze overrides every state.
    always_comb begin
        state_nxt = state;
        load_go   = 1'b0;
        if (freeze) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && any_req) begin
                        state_nxt = CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CALC: begin
                    if (cand_ok) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                READ: begin
                    state_nxt = CHECK;
                end
                CHECK: begin
                    if (wallQ) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    if (busy) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                        load_go   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and held candidate; init_pend draws the start position once after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nextX     <= 8'(START_X);
            nextY     <= 7'(START_Y);
            dir       <= DIR_NONE;
            ldXY      <= 1'b0;
            moving    <= 1'b0;
            wallAddr  <= 11'd0;
            held_x    <= 8'd0;
            held_y    <= 7'd0;
            init_pend <= 1'b1;
        end else begin
            init_pend <= 1'b0;
            ldXY      <= init_pend | load_go;
            moving    <= (state_nxt != IDLE);
            if (state == IDLE && state_nxt == CALC) begin
                dir <= pick_dir(iUp, iDown, iLeft, iRight);
            end
            if (state_nxt == IDLE) begin
                wallAddr <= 11'd0;
            end else if (state == CALC) begin
                wallAddr <= cand_addr;
                held_x   <= cand_x[7:0];
                held_y   <= cand_y[6:0];
            end
            if (load_go) begin
                nextX <= held_x;
                nextY <= held_y;
            end
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Self-checking bench for player_mover: directed scenarios plus randomized moves against a position model.
module tb_player_mover;

    localparam int STEP  = 4;
    localparam int X_MAX = 156;
    localparam int Y_MAX = 116;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, iUp = 1'b0, iDown = 1'b0, iLeft = 1'b0, iRight = 1'b0;
    logic        freeze = 1'b0, busy = 1'b0, wallQ = 1'b0;
    logic [10:0] wallAddr;
    logic [7:0]  nextX;
    logic [6:0]  nextY;
    logic [2:0]  dir;
    logic        ldXY, moving;

    logic        wall_map [0:2047];
    int          checks = 0;
    int          errors = 0;
    int          mx, my, mdir;

    int          ld_count, ld_obs, ld_x, ld_y, addr1;
    bit          dbl;
    logic [31:0] mov_trace;
    int          exp_ld, exp_addr;

    player_mover dut (
        .clock(clock), .reset(reset), .tick(tick),
        .iUp(iUp), .iDown(iDown), .iLeft(iLeft), .iRight(iRight),
        .freeze(freeze), .busy(busy), .wallAddr(wallAddr), .wallQ(wallQ),
        .nextX(nextX), .nextY(nextY), .dir(dir), .ldXY(ldXY), .moving(moving)
    );

    always #5 clock = ~clock;

    // Synchronous wall ROM: data follows the address by one cycle.
    always @(posedge clock) wallQ <= wall_map[wallAddr];

    // Reference: one move attempt, from the game rules in plain integers.
    task automatic model_move(input logic u, input logic d, input logic l, input logic r,
                              output int e_ld, output int e_addr);
        int dx, dy, cx, cy;
        bit blocked;
        e_ld = 0;
        e_addr = 0;
        if (!(u || d || l || r)) return;
        dx = 0;
        dy = 0;
        if (u)      begin dy = -STEP; mdir = 1; end
        else if (d) begin dy = STEP;  mdir = 2; end
        else if (l) begin dx = -STEP; mdir = 3; end
        else        begin dx = STEP;  mdir = 4; end
        cx = mx + dx;
        cy = my + dy;
        blocked = (cy < 0) || (cy > Y_MAX);
`ifdef MOVER_WRAP_EN
        if (cx < 0) cx = X_MAX;
        else if (cx > X_MAX) cx = 0;
`else
        if (cx < 0 || cx > X_MAX) blocked = 1'b1;
`endif
        if (blocked) return;
        e_addr = (cy / 4) * 40 + cx / 4;
        if (wall_map[e_addr]) return;
        e_ld = 1;
        mx = cx;
        my = cy;
    endtask

    // Drives one tick with the given requests and records what the DUT does; starts and ends at a negedge.
    task automatic run_move(input logic u, input logic d, input logic l, input logic r,
                            input int stall, input int freeze_at, input bit tick_again,
                            output int o_cnt, output int o_obs, output int o_x, output int o_y,
                            output int o_addr1, output bit o_dbl, output logic [31:0] o_mov);
        bit prev;
        o_cnt = 0; o_obs = -1; o_x = -1; o_y = -1; o_addr1 = -1; o_dbl = 1'b0; o_mov = 32'd0;
        prev = 1'b0;
        iUp = u; iDown = d; iLeft = l; iRight = r;
        tick = 1'b1;
        busy = (stall > 0);
        freeze = (freeze_at == 0);
        for (int k = 0; k < 10 + stall; k++) begin
            @(negedge clock);
            tick = (tick_again && k == 1);
            busy = (stall > 0) && (k < 3 + stall);
            freeze = (freeze_at >= 0) && (k + 1 >= freeze_at);
            if (k < 32) o_mov[k] = moving;
            if (k == 1) o_addr1 = int'(wallAddr);
            if (ldXY) begin
                if (prev) o_dbl = 1'b1;
                o_cnt++;
                if (o_obs < 0) begin
                    o_obs = k; o_x = int'(nextX); o_y = int'(nextY);
                end
            end
            prev = ldXY;
        end
        iUp = 1'b0; iDown = 1'b0; iLeft = 1'b0; iRight = 1'b0; busy = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        checks++; if (ldXY !== 1'b0 || moving !== 1'b0) begin errors++; $display("FAIL reset_flags got ld=%b mv=%b want 0 0", ldXY, moving); end
        checks++; if (wallAddr !== 11'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", wallAddr); end
        checks++; if (nextX !== 8'd2 || nextY !== 7'd2 || dir !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d,%0d dir %0d want 2,2 dir 0", nextX, nextY, dir); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (ldXY !== 1'b1 || nextX !== 8'd2 || nextY !== 7'd2 || dir !== 3'd0) begin errors++; $display("FAIL reset_draw got ld=%b %0d,%0d dir %0d want 1 2,2 0", ldXY, nextX, nextY, dir); end
        @(negedge clock);
        checks++; if (ldXY !== 1'b0) begin errors++; $display("FAIL reset_single got ld=%b want 0", ldXY); end
        mx = 2; my = 2; mdir = 0;
    endtask

    task automatic test_free_move();
        model_move(1'b0, 1'b0, 1'b0, 1'b1, exp_ld, exp_addr);
        run_move(1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 1 || ld_obs !== 4) begin errors++; $display("FAIL free_ld got cnt %0d at %0d want 1 at 4", ld_count, ld_obs); end
        checks++; if (ld_x !== 6 || ld_y !== 2) begin errors++; $display("FAIL free_pos got %0d,%0d want 6,2", ld_x, ld_y); end
        checks++; if (dir !== 3'd4 || addr1 !== 1) begin errors++; $display("FAIL free_dir_addr got dir %0d addr %0d want 4 1", dir, addr1); end
        checks++; if (mov_trace[3:0] !== 4'b1111) begin errors++; $display("FAIL free_moving got %b want 1111", mov_trace[3:0]); end
    endtask

    task automatic test_wall_priority();
        model_move(1'b0, 1'b1, 1'b0, 1'b0, exp_ld, exp_addr);
        run_move(1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 1 || ld_x !== 6 || ld_y !== 6) begin errors++; $display("FAIL down_move got cnt %0d %0d,%0d want 1 6,6", ld_count, ld_x, ld_y); end
        wall_map[1] = 1'b1;
        model_move(1'b1, 1'b0, 1'b1, 1'b0, exp_ld, exp_addr);
        run_move(1'b1, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 0 || dir !== 3'd1) begin errors++; $display("FAIL wall_block got cnt %0d dir %0d want 0 1", ld_count, dir); end
        checks++; if (nextX !== 8'd6 || nextY !== 7'd6 || addr1 !== 1) begin errors++; $display("FAIL wall_pos got %0d,%0d addr %0d want 6,6 1", nextX, nextY, addr1); end
        wall_map[1] = 1'b0;
    endtask

    task automatic test_busy_stall();
        model_move(1'b0, 1'b0, 1'b0, 1'b1, exp_ld, exp_addr);
        run_move(1'b0, 1'b0, 1'b0, 1'b1, 10, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 1 || ld_obs !== 14 || dbl) begin errors++; $display("FAIL busy_ld got cnt %0d at %0d dbl %0b want 1 at 14", ld_count, ld_obs, dbl); end
        checks++; if (ld_x !== 10 || ld_y !== 6) begin errors++; $display("FAIL busy_pos got %0d,%0d want 10,6", ld_x, ld_y); end
    endtask

    task automatic test_freeze();
        run_move(1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        mdir = 3;
        checks++; if (mov_trace[2:0] !== 3'b011 || ld_count !== 0) begin errors++; $display("FAIL freeze_abort got mov %b cnt %0d want 011 0", mov_trace[2:0], ld_count); end
        checks++; if (nextX !== 8'd10 || dir !== 3'd3) begin errors++; $display("FAIL freeze_hold got x %0d dir %0d want 10 3", nextX, dir); end
        run_move(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (mov_trace !== 32'd0 || ld_count !== 0 || dir !== 3'd3) begin errors++; $display("FAIL freeze_ignore got mov %h cnt %0d dir %0d want 0 0 3", mov_trace, ld_count, dir); end
        freeze = 1'b0;
    endtask

    task automatic test_tick_ignored();
        model_move(1'b0, 1'b1, 1'b0, 1'b0, exp_ld, exp_addr);
        run_move(1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 1'b1, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 1 || int'(nextY) !== my || my !== 10) begin errors++; $display("FAIL tick_ignored got cnt %0d y %0d want 1 10", ld_count, nextY); end
    endtask

    task automatic test_edge();
        logic [3:0] setup [4];
        setup[0] = 4'b0010; setup[1] = 4'b0010; setup[2] = 4'b1000; setup[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            model_move(setup[i][3], setup[i][2], setup[i][1], setup[i][0], exp_ld, exp_addr);
            run_move(setup[i][3], setup[i][2], setup[i][1], setup[i][0], 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        end
        checks++; if (nextX !== 8'd2 || nextY !== 7'd2) begin errors++; $display("FAIL edge_setup got %0d,%0d want 2,2", nextX, nextY); end
        model_move(1'b1, 1'b0, 1'b0, 1'b0, exp_ld, exp_addr);
        run_move(1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
        checks++; if (ld_count !== 0 || nextY !== 7'd2 || addr1 !== 0 || dir !== 3'd1) begin errors++; $display("FAIL edge_top got cnt %0d y %0d addr %0d dir %0d want 0 2 0 1", ld_count, nextY, addr1, dir); end
        model_move(1'b0, 1'b0, 1'b1, 1'b0, exp_ld, exp_addr);
        run_move(1'b0, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
`ifdef MOVER_WRAP_EN
        checks++; if (ld_count !== 1 || ld_x !== 156 || addr1 !== 39) begin errors++; $display("FAIL edge_wrap got cnt %0d x %0d addr %0d want 1 156 39", ld_count, ld_x, addr1); end
`else
        checks++; if (ld_count !== 0 || nextX !== 8'd2 || addr1 !== 0) begin errors++; $display("FAIL edge_left got cnt %0d x %0d addr %0d want 0 2 0", ld_count, nextX, addr1); end
`endif
    endtask

    task automatic test_reset_mid_move();
        int cnt, first;
        iRight = 1'b1; tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (moving !== 1'b0 || ldXY !== 1'b0 || wallAddr !== 11'd0) begin errors++; $display("FAIL midreset_async got mv %b ld %b addr %0d want 0 0 0", moving, ldXY, wallAddr); end
        @(negedge clock);
        reset = 1'b0; iRight = 1'b0;
        cnt = 0; first = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (ldXY) begin cnt++; if (first < 0) first = k; end
        end
        checks++; if (cnt !== 1 || first !== 0 || nextX !== 8'd2 || nextY !== 7'd2 || dir !== 3'd0) begin errors++; $display("FAIL midreset_abort got cnt %0d at %0d pos %0d,%0d dir %0d want 1 at 0 2,2 0", cnt, first, nextX, nextY, dir); end
        mx = 2; my = 2; mdir = 0;
    endtask

    task automatic test_random();
        logic [3:0] req;
        int stall;
        for (int a = 0; a < 2048; a++) wall_map[a] = ($urandom_range(0, 3) == 0);
        for (int n = 0; n < 60; n++) begin
            req = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 3);
            model_move(req[3], req[2], req[1], req[0], exp_ld, exp_addr);
            run_move(req[3], req[2], req[1], req[0], stall, -1, 1'b0, ld_count, ld_obs, ld_x, ld_y, addr1, dbl, mov_trace);
            checks++; if (ld_count !== exp_ld || dbl) begin errors++; $display("FAIL rand_ld n=%0d got cnt %0d want %0d", n, ld_count, exp_ld); end
            if (exp_ld == 1) begin
                checks++; if (ld_obs !== 4 + stall || ld_x !== mx || ld_y !== my) begin errors++; $display("FAIL rand_load n=%0d got at %0d %0d,%0d want at %0d %0d,%0d", n, ld_obs, ld_x, ld_y, 4 + stall, mx, my); end
            end
            checks++; if (int'(nextX) !== mx || int'(nextY) !== my || int'(dir) !== mdir) begin errors++; $display("FAIL rand_state n=%0d got %0d,%0d dir %0d want %0d,%0d dir %0d", n, nextX, nextY, dir, mx, my, mdir); end
            checks++; if (addr1 !== exp_addr || mov_trace[0] !== (req != 4'd0)) begin errors++; $display("FAIL rand_addr n=%0d got addr %0d mv %b want %0d %b", n, addr1, mov_trace[0], exp_addr, req != 4'd0); end
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) wall_map[a] = 1'b0;
        test_reset();
        test_free_move();
        test_wall_priority();
        test_busy_stall();
        test_freeze();
        test_tick_ignored();
        test_edge();
        test_reset_mid_move();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 SHALL have parameters: STEP, default 4, pixels moved per accepted step.
REQ-002 SHALL have parameters: START_X, default 2; START_Y, default 2; reset position.
REQ-003 SHALL have parameters: X_MAX, default 156; Y_MAX, default 116; largest legal sprite origin.
REQ-004 SHALL have ports: clock  in  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: tick  in  1  one-cycle movement-rate enable.
REQ-007 SHALL have ports: iUp, iDown, iLeft, iRight  in  1 each  level direction requests.
REQ-008 SHALL have ports: freeze  in  1  game over (won or timesUp); blocks motion.
REQ-009 SHALL have ports: busy  in  1  animation block still drawing; delays load.
REQ-010 SHALL have ports: wallAddr  out  11  wall-map ROM address.
REQ-011 SHALL have ports: wallQ  in  1  wall flag for that address, valid one cycle after the address.
REQ-012 SHALL have ports: nextX  out  8  and  nextY  out  7  committed sprite origin.
REQ-013 SHALL have ports: dir  out  3  heading, 0 none, 1 up, 2 down, 3 left, 4 right.
REQ-014 SHALL have ports: ldXY  out  1  one-cycle pulse marking a new nextX/nextY.
REQ-015 SHALL have ports: moving  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL run FSM states IDLE, CALC, READ, CHECK, LOAD.
REQ-017 IDLE->CALC SHALL occur when tick=1, freeze=0 and at least one request is high.
REQ-018 Simultaneous requests SHALL resolve by priority up > down > left > right.
REQ-019 The chosen heading SHALL be latched into dir at IDLE->CALC, including for moves later blocked.
REQ-020 CALC SHALL form candidate = committed position ± STEP on one axis, computed with 9-bit arithmetic.
REQ-021 A candidate below 0 or above X_MAX/Y_MAX SHALL return the FSM to IDLE, with the position unchanged and no ldXY.
REQ-022 In CALC->READ, the block SHALL drive wallAddr = (candY>>2)*40 + (candX>>2) and hold it through CHECK.
REQ-023 In CHECK, wallQ=1 SHALL go to IDLE with no move; wallQ=0 SHALL go to LOAD.
REQ-024 LOAD SHALL wait while busy=1; on the first cycle with busy=0 it SHALL update nextX/nextY, pulse ldXY for exactly one cycle, and return to IDLE.
REQ-025 ldXY and the new coordinates SHALL appear on the same cycle.
REQ-026 Minimum latency from the tick cycle to ldXY SHALL be 4 cycles.
REQ-027 ldXY SHALL never be high for two consecutive cycles.
REQ-028 tick pulses arriving outside IDLE SHALL be ignored, not queued.
REQ-029 freeze=1 in any state SHALL force IDLE next cycle with no ldXY; nextX/nextY/dir SHALL hold.
REQ-030 wallAddr SHALL be 0 in IDLE.

Reset
REQ-031 On reset: state IDLE; nextX=START_X; nextY=START_Y; dir=0; ldXY=0; moving=0; wallAddr=0.
REQ-032 Reset asserted mid-move SHALL abort the move; no ldXY SHALL be emitted for it.
REQ-033 After reset deasserts, the first clock edge SHALL pulse ldXY once so the start position is drawn.

Configuration
REQ-034 Macro MOVER_WRAP_EN defined: a left candidate below 0 SHALL wrap to X_MAX, and a right candidate above X_MAX SHALL wrap to 0; the wrapped candidate then goes through the normal wall check.
REQ-035 MOVER_WRAP_EN undefined: horizontal out-of-bounds SHALL be blocked per REQ-021.
REQ-036 Vertical bounds SHALL always block, regardless of MOVER_WRAP_EN.

Verification
REQ-037 Reset release: reset 1->0 -> ldXY pulses once with nextX=2, nextY=2, dir=0.
REQ-038 Free move: tick, iRight=1, wallQ=0, busy=0 -> ldXY 4 cycles later with nextX=6, nextY=2, dir=4, wallAddr=1.
REQ-039 Wall and priority: iUp=1 and iLeft=1 with wallQ=1 -> dir=1, no ldXY, position unchanged.
REQ-040 Busy stall: busy=1 for 10 cycles in LOAD -> ldXY on the first cycle busy=0, single pulse.
REQ-041 Freeze: freeze=1 during READ -> IDLE next cycle, no ldXY; later ticks are ignored while freeze=1.
REQ-042 Edge: at nextX=0, tick+iLeft -> blocked without MOVER_WRAP_EN; with it, wallAddr=39 and nextX=156 on ldXY.
